// File: rtl/alu_op_sequencer.sv
// Issues one ALU_8Bit operation at a time behind a valid/ready request/response pair.
// It holds the ALU inputs steady for a per-class settle time and then keeps the response until it is accepted.
module alu_op_sequencer #(
    parameter int unsigned FAST_CYCLES = 1,
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned DIV_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sub,
    output logic [2:0] alu_op_select,
    input  logic [7:0] alu_result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] FAST_LOAD = 4'(FAST_CYCLES - 1);
    localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic [3:0] cnt_r;
    logic       op_illegal_s;
    logic       div_zero_s;
    logic       early_done_s;

    // Counter load value: settle cycles minus one, since the EXEC entry edge is the first cycle.
    function automatic logic [3:0] settle_load(input logic [2:0] op);
        logic [3:0] load;
        case (op)
            3'd4:    load = MUL_LOAD;
            3'd5:    load = DIV_LOAD;
            default: load = FAST_LOAD;
        endcase
        return load;
    endfunction

    // Requests that complete without touching the ALU.
    always_comb begin
        op_illegal_s = (req_op > 3'd5);
        div_zero_s   = (req_op == 3'd5) && (req_b == 8'd0);
        early_done_s = op_illegal_s || div_zero_s;
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (early_done_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_EXEC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and handshake flags; the flags are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            req_ready <= (next_state_s == ST_IDLE);
            rsp_valid <= (next_state_s == ST_DONE);
            busy      <= (next_state_s != ST_IDLE);
        end
    end

    // Operand latch, settle counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r         <= 4'd0;
            alu_a         <= 8'd0;
            alu_b         <= 8'd0;
            alu_sub       <= 1'b0;
            alu_op_select <= 3'd0;
            rsp_result    <= 8'd0;
            rsp_zero      <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a         <= req_a;
                        alu_b         <= req_b;
                        alu_sub       <= (req_op == 3'd1);
                        alu_op_select <= req_op;
                        cnt_r         <= settle_load(req_op);
                        if (op_illegal_s) begin
                            rsp_result <= 8'd0;
                            rsp_zero   <= 1'b1;
                            rsp_err    <= 1'b1;
                        end else if (div_zero_s) begin
                            rsp_result <= 8'hFF;
                            rsp_zero   <= 1'b0;
                            rsp_err    <= 1'b1;
                        end else begin
                            rsp_result <= rsp_result;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= (alu_result == 8'd0);
                        rsp_err    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer with a behavioural ALU_8Bit model on the alu_* side.
module tb_alu_op_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_err;
    logic       busy;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sub;
    logic [2:0] alu_op_select;
    logic [7:0] alu_result;
    logic [15:0] prod_s;

    int tests_run = 0;
    int tests_failed = 0;

    alu_op_sequencer #(.FAST_CYCLES(1), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .alu_op_select(alu_op_select), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 8-bit wrap-around arithmetic.
    always_comb begin
        prod_s = 16'(alu_a) * 16'(alu_b);
        case (alu_op_select)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = prod_s[7:0];
            3'd5:    alu_result = (alu_b == 8'd0) ? 8'hFF : (alu_a / alu_b);
            default: alu_result = 8'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (accepted when the sequencer is idle).
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick();
        req_valid = 1'b0;
    endtask

    // Count edges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if ({alu_a, alu_b, alu_sub, alu_op_select} !== 20'd0) begin tests_failed++; $display("FAIL reset_alu got %h/%h/%b/%h exp 0", alu_a, alu_b, alu_sub, alu_op_select); end
        tests_run++; if ({rsp_result, rsp_zero, rsp_err} !== 10'd0) begin tests_failed++; $display("FAIL reset_rsp got %h/%b/%b exp 0", rsp_result, rsp_zero, rsp_err); end
        reset = 1'b0;
        tick();
        tests_run++; if (req_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got ready=%b busy=%b exp 1/0", req_ready, busy); end
    endtask

    task automatic test_add();
        int lat;
        issue(3'd0, 8'd200, 8'd100);
        tests_run++; if (busy !== 1'b1 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL add_busy got busy=%b ready=%b exp 1/0", busy, req_ready); end
        wait_rsp(lat);
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL add_latency got %0d exp 1", lat); end
        tests_run++; if (rsp_result !== 8'd44 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL add_result got %0d/%b/%b exp 44/0/0", rsp_result, rsp_zero, rsp_err); end
        release_rsp();
        tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL add_release got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_sub_zero();
        int lat;
        issue(3'd1, 8'h5A, 8'h5A);
        tests_run++; if (alu_sub !== 1'b1 || alu_op_select !== 3'd1) begin tests_failed++; $display("FAIL sub_alu_sub got %b/%0d exp 1/1", alu_sub, alu_op_select); end
        wait_rsp(lat);
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL sub_latency got %0d exp 1", lat); end
        tests_run++; if (rsp_result !== 8'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL sub_result got %h/%b/%b exp 00/1/0", rsp_result, rsp_zero, rsp_err); end
        release_rsp();
    endtask

    task automatic test_mul();
        issue(3'd4, 8'd12, 8'd11);
        tests_run++; if (alu_sub !== 1'b0) begin tests_failed++; $display("FAIL mul_alu_sub got %b exp 0", alu_sub); end
        for (int i = 1; i <= 4; i++) begin
            tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mul_early_valid edge %0d got %b exp 0", i - 1, rsp_valid); end
            tests_run++; if (alu_a !== 8'd12 || alu_b !== 8'd11) begin tests_failed++; $display("FAIL mul_alu_stable got %0d/%0d exp 12/11", alu_a, alu_b); end
            tick();
        end
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL mul_latency got valid=%b exp 1 at edge 4", rsp_valid); end
        tests_run++; if (rsp_result !== 8'd132 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL mul_result got %0d/%b/%b exp 132/0/0", rsp_result, rsp_zero, rsp_err); end
        release_rsp();
    endtask

    task automatic test_div();
        int lat;
        issue(3'd5, 8'd100, 8'd7);
        wait_rsp(lat);
        tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL div_latency got %0d exp 8", lat); end
        tests_run++; if (rsp_result !== 8'd14 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL div_result got %0d/%b exp 14/0", rsp_result, rsp_err); end
        release_rsp();
        issue(3'd5, 8'd9, 8'd0);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL div0_latency got valid=%b exp 1", rsp_valid); end
        tests_run++; if (rsp_result !== 8'hFF || rsp_zero !== 1'b0 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL div0_result got %h/%b/%b exp FF/0/1", rsp_result, rsp_zero, rsp_err); end
        release_rsp();
        issue(3'd7, 8'd3, 8'd4);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL illegal_latency got valid=%b exp 1", rsp_valid); end
        tests_run++; if (rsp_result !== 8'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL illegal_result got %h/%b/%b exp 00/1/1", rsp_result, rsp_zero, rsp_err); end
        tests_run++; if (alu_op_select !== 3'd7) begin tests_failed++; $display("FAIL illegal_latch got %0d exp 7", alu_op_select); end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(3'd2, 8'hF3, 8'h3C);
        wait_rsp(lat);
        // A competing request is held high through the backpressure window.
        req_valid = 1'b1; req_op = 3'd3; req_a = 8'hF0; req_b = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h30 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL bp_hold cycle %0d got %b/%h/%b/%b exp 1/30/0/0", i, rsp_valid, rsp_result, rsp_zero, rsp_err); end
            tests_run++; if (alu_a !== 8'hF3 || alu_op_select !== 3'd2) begin tests_failed++; $display("FAIL bp_ignore_req got %h/%0d exp F3/2", alu_a, alu_op_select); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 8'hF3) begin tests_failed++; $display("FAIL b2b_idle got ready=%b valid=%b a=%h exp 1/0/F3", req_ready, rsp_valid, alu_a); end
        tick();
        req_valid = 1'b0;
        tests_run++; if (alu_a !== 8'hF0 || alu_op_select !== 3'd3 || busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got a=%h op=%0d busy=%b exp F0/3/1", alu_a, alu_op_select, busy); end
        wait_rsp(lat);
        tests_run++; if (lat != 1 || rsp_result !== 8'hFF || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_result got lat=%0d %h/%b exp 1/FF/0", lat, rsp_result, rsp_err); end
        release_rsp();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen;
        issue(3'd5, 8'd200, 8'd10);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags got ready=%b busy=%b valid=%b exp 1/0/0", req_ready, busy, rsp_valid); end
        tests_run++; if ({alu_a, alu_b, alu_op_select, rsp_result, rsp_err} !== 28'd0) begin tests_failed++; $display("FAIL rst_mid_regs got a=%h b=%h op=%0d res=%h err=%b exp 0", alu_a, alu_b, alu_op_select, rsp_result, rsp_err); end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL rst_mid_no_rsp got %0d active cycles exp 0", seen); end
        issue(3'd0, 8'd1, 8'd1);
        wait_rsp(lat);
        tests_run++; if (lat != 1 || rsp_result !== 8'd2 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_next got lat=%0d %0d/%b exp 1/2/0", lat, rsp_result, rsp_err); end
        release_rsp();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0; rsp_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_add();
        test_sub_zero();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
